// File: rtl/dec_stream_loader_pkg.sv
// dec_stream_loader_pkg: shared constants and state encoding for the
// ASCII decimal operand loader and its byte classifier.
package dec_stream_loader_pkg;

    localparam logic [7:0] ASCII_ZERO  = 8'h30;
    localparam logic [7:0] ASCII_NINE  = 8'h39;
    localparam logic [7:0] ASCII_SP    = 8'h20;
    localparam logic [7:0] ASCII_TAB   = 8'h09;
    localparam logic [7:0] ASCII_CR    = 8'h0D;
    localparam logic [7:0] ASCII_LF    = 8'h0A;
    localparam logic [7:0] ASCII_COMMA = 8'h2C;

    // Operand storage layout: matrix1, then vector, then matrix2.
    localparam int MAT1_BASE = 0;
    localparam int VEC_BASE  = 16;
    localparam int MAT2_BASE = 20;
    localparam int NUM_ITEMS = 36;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

endpackage

// File: rtl/dec_stream_loader_ascii_classify.sv
// ascii_classify: combinational byte classifier.
// Ports: byte_i in; is_digit/is_delim/is_illegal flags and digit value out.
module ascii_classify
    import dec_stream_loader_pkg::*;
(
    input  logic [7:0] byte_i,
    output logic       is_digit,
    output logic       is_delim,
    output logic       is_illegal,
    output logic [3:0] digit
);

    always_comb begin
        is_digit   = byte_i inside {[ASCII_ZERO:ASCII_NINE]};
        is_delim   = byte_i inside {ASCII_SP, ASCII_TAB, ASCII_CR,
                                    ASCII_LF, ASCII_COMMA};
        is_illegal = !is_digit && !is_delim;
        // ASCII '0'..'9' carry their value in the low nibble.
        digit      = is_digit ? byte_i[3:0] : 4'd0;
    end

endmodule

// File: rtl/dec_stream_loader.sv
// dec_stream_loader: parses ASCII decimal numbers from the UART byte
// stream and writes them as indexed items into operand storage.
// Ports: clk, reset, restart; rx_valid/rx_byte/rx_error from UART;
// wr_en/wr_addr/wr_data to storage; item_count, load_done, error flags.
module dec_stream_loader
    import dec_stream_loader_pkg::*;
#(
    parameter int VAL_W      = 8,
    parameter int NUM_ITEMS  = 36,
    parameter int MAX_DIGITS = 3,
    parameter int ADDR_W     = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              restart,
    input  logic              rx_valid,
    input  logic [7:0]        rx_byte,
    input  logic              rx_error,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [VAL_W-1:0]  wr_data,
    output logic [ADDR_W-1:0] item_count,
    output logic              load_done,
    output logic              overflow_err,
    output logic              format_err
);

    localparam int ACC_W  = VAL_W + 4;
    localparam int DCNT_W = $clog2(MAX_DIGITS + 1);

    localparam logic [ACC_W-1:0]   ACC_MAX  = '1;
    localparam logic [ACC_W-1:0]   VAL_MAX  = {4'b0, {VAL_W{1'b1}}};
    localparam logic [ACC_W+3:0]   TEN      = (ACC_W + 4)'(10);
    localparam logic [DCNT_W-1:0]  DCNT_MAX = DCNT_W'(MAX_DIGITS);
    localparam logic [ADDR_W-1:0]  LAST_IDX = ADDR_W'(NUM_ITEMS - 1);

    state_e              state_q, state_d;
    logic [ACC_W-1:0]    acc_q, acc_d;
    logic [DCNT_W-1:0]   dcnt_q, dcnt_d;
    logic                wr_en_q, wr_en_d;
    logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
    logic [VAL_W-1:0]    wr_data_q, wr_data_d;
    logic [ADDR_W-1:0]   count_q, count_d;
    logic                done_q, done_d;
    logic                ovf_q, ovf_d;
    logic                fmt_q, fmt_d;

    logic                is_digit, is_delim, is_illegal;
    logic [3:0]          digit;

    logic                tok_bad, tok_dlm, tok_dig;
    logic [ACC_W-1:0]    acc_base, acc_step;
    logic [ACC_W+3:0]    prod;
    logic [DCNT_W-1:0]   dcnt_step;
    logic                commit;
    logic [ACC_W-1:0]    commit_val;

    ascii_classify u_cls (
        .byte_i     (rx_byte),
        .is_digit   (is_digit),
        .is_delim   (is_delim),
        .is_illegal (is_illegal),
        .digit      (digit)
    );

    // A framing error poisons any byte arriving with it, so the three
    // token kinds are mutually exclusive.
    always_comb begin
        tok_bad = rx_error || (rx_valid && is_illegal);
        tok_dlm = rx_valid && !rx_error && is_delim;
        tok_dig = rx_valid && !rx_error && is_digit;
    end

    // Next accumulator value if the current byte is a digit. In IDLE the
    // number starts from zero, so both states share one datapath.
    always_comb begin
        acc_base  = (state_q == ST_ACCUM) ? acc_q : '0;
        prod      = {4'b0, acc_base} * TEN + {{ACC_W{1'b0}}, digit};
        acc_step  = (prod > {4'b0, ACC_MAX}) ? ACC_MAX : prod[ACC_W-1:0];
        dcnt_step = ((state_q == ST_ACCUM) ? dcnt_q : '0) + DCNT_W'(1);
    end

    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        dcnt_d     = dcnt_q;
        wr_en_d    = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        count_d    = count_q;
        done_d     = done_q;
        ovf_d      = ovf_q;
        fmt_d      = fmt_q;
        commit     = 1'b0;
        commit_val = acc_q;

        if (state_q != ST_DONE) begin
            unique case (1'b1)
                tok_bad: begin
                    fmt_d   = 1'b1;
                    acc_d   = '0;
                    dcnt_d  = '0;
                    state_d = ST_IDLE;
                end
                tok_dlm: begin
                    // Delimiters in IDLE are padding, not empty items.
                    if (state_q == ST_ACCUM) begin
                        commit = 1'b1;
                    end
                end
                tok_dig: begin
                    acc_d   = acc_step;
                    dcnt_d  = dcnt_step;
                    state_d = ST_ACCUM;
                    if (dcnt_step == DCNT_MAX) begin
                        commit     = 1'b1;
                        commit_val = acc_step;
                    end
                end
                default: ;
            endcase
        end

        if (commit) begin
            wr_en_d   = 1'b1;
            wr_addr_d = count_q;
            count_d   = count_q + ADDR_W'(1);
            acc_d     = '0;
            dcnt_d    = '0;
            if (commit_val > VAL_MAX) begin
                wr_data_d = '1;
                ovf_d     = 1'b1;
            end else begin
                wr_data_d = commit_val[VAL_W-1:0];
            end
            if (count_q == LAST_IDX) begin
                done_d  = 1'b1;
                state_d = ST_DONE;
            end else begin
                state_d = ST_IDLE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset || restart) begin
            state_q   <= ST_IDLE;
            acc_q     <= '0;
            dcnt_q    <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            count_q   <= '0;
            done_q    <= 1'b0;
            ovf_q     <= 1'b0;
            fmt_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            dcnt_q    <= dcnt_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            count_q   <= count_d;
            done_q    <= done_d;
            ovf_q     <= ovf_d;
            fmt_q     <= fmt_d;
        end
    end

    assign wr_en        = wr_en_q;
    assign wr_addr      = wr_addr_q;
    assign wr_data      = wr_data_q;
    assign item_count   = count_q;
    assign load_done    = done_q;
    assign overflow_err = ovf_q;
    assign format_err   = fmt_q;

endmodule

// File: tb/tb_dec_stream_loader.sv
// tb_dec_stream_loader: table vectors, hand sequences and a randomized
// run against a byte-level reference model of the decimal loader.
module tb_dec_stream_loader;

    logic       clk = 1'b0;
    logic       reset;
    logic       restart;
    logic       rx_valid;
    logic [7:0] rx_byte;
    logic       rx_error;
    logic       wr_en;
    logic [5:0] wr_addr;
    logic [7:0] wr_data;
    logic [5:0] item_count;
    logic       load_done;
    logic       overflow_err;
    logic       format_err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dec_stream_loader dut (
        .clk          (clk),
        .reset        (reset),
        .restart      (restart),
        .rx_valid     (rx_valid),
        .rx_byte      (rx_byte),
        .rx_error     (rx_error),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .item_count   (item_count),
        .load_done    (load_done),
        .overflow_err (overflow_err),
        .format_err   (format_err)
    );

    // Reference model: a number is a run of digits; it ends on a
    // delimiter or on its third digit. Plain integers, no FSM.
    int  m_digits, m_value, m_count, e_addr, e_data;
    bit  m_done, m_ovf, m_fmt, e_wr;

    function automatic bit is_dig(input logic [7:0] b);
        return b >= 8'h30 && b <= 8'h39;
    endfunction

    function automatic bit is_dlm(input logic [7:0] b);
        return b == 8'h20 || b == 8'h09 || b == 8'h0D ||
               b == 8'h0A || b == 8'h2C;
    endfunction

    function automatic void m_clear();
        m_digits = 0; m_value = 0; m_count = 0;
        e_addr = 0; e_data = 0; e_wr = 0;
        m_done = 0; m_ovf = 0; m_fmt = 0;
    endfunction

    function automatic void m_commit();
        e_wr   = 1;
        e_addr = m_count;
        e_data = (m_value > 255) ? 255 : m_value;
        if (m_value > 255) m_ovf = 1;
        m_count++;
        m_digits = 0;
        m_value  = 0;
        if (m_count == 36) m_done = 1;
    endfunction

    function automatic void m_step(input bit rs, input bit v,
                                   input logic [7:0] b, input bit e);
        e_wr = 0;
        if (rs) begin
            m_clear();
            return;
        end
        if (m_done) return;
        if (e || (v && !is_dig(b) && !is_dlm(b))) begin
            m_fmt = 1;
            m_digits = 0;
            m_value = 0;
            return;
        end
        if (!v) return;
        if (is_dlm(b)) begin
            if (m_digits > 0) m_commit();
            return;
        end
        m_value = m_value * 10 + int'(b - 8'h30);
        if (m_value > 4095) m_value = 4095;
        m_digits++;
        if (m_digits == 3) m_commit();
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)",
                     nm, act, exp, $time);
        end
    endtask

    // One clock of stimulus; model advanced in lockstep.
    task automatic cyc(input bit rst, input bit rs, input bit v,
                       input logic [7:0] b, input bit e);
        @(negedge clk);
        reset    = rst;
        restart  = rs;
        rx_valid = v;
        rx_byte  = b;
        rx_error = e;
        @(posedge clk);
        #1;
        m_step(rst || rs, v, b, e);
        reset    = 1'b0;
        restart  = 1'b0;
        rx_valid = 1'b0;
        rx_error = 1'b0;
    endtask

    task automatic chk_model(input string tag);
        chk({tag, ".wr_en"}, int'(wr_en), int'(e_wr));
        chk({tag, ".wr_addr"}, int'(wr_addr), e_addr);
        chk({tag, ".wr_data"}, int'(wr_data), e_data);
        chk({tag, ".item_count"}, int'(item_count), m_count);
        chk({tag, ".load_done"}, int'(load_done), int'(m_done));
        chk({tag, ".overflow_err"}, int'(overflow_err), int'(m_ovf));
        chk({tag, ".format_err"}, int'(format_err), int'(m_fmt));
    endtask

    typedef struct {
        bit         rs;
        bit         v;
        logic [7:0] b;
        bit         e;
        bit         wr;
        int         ad;
        int         da;
        int         cnt;
        bit         dn;
        bit         ov;
        bit         fm;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(input bit rs, input bit v,
                                input logic [7:0] b, input bit e,
                                input bit wr, input int ad, input int da,
                                input int cnt, input bit ov, input bit fm);
        vec_t r;
        r.rs = rs; r.v = v; r.b = b; r.e = e;
        r.wr = wr; r.ad = ad; r.da = da; r.cnt = cnt;
        r.dn = 0; r.ov = ov; r.fm = fm;
        tbl.push_back(r);
    endfunction

    function automatic void ch(input logic [7:0] b, input bit wr,
                               input int ad, input int da, input int cnt,
                               input bit ov, input bit fm);
        add(0, 1, b, 0, wr, ad, da, cnt, ov, fm);
    endfunction

    function automatic void rst_row();
        add(1, 0, 8'h00, 0, 0, 0, 0, 0, 0, 0);
    endfunction

    function automatic void build_table();
        rst_row();
        ch("1", 0, 0, 0, 0, 0, 0);
        ch("2", 0, 0, 0, 0, 0, 0);
        ch("3", 1, 0, 123, 1, 0, 0);
        rst_row();
        ch("7", 0, 0, 0, 0, 0, 0);
        ch(" ", 1, 0, 7, 1, 0, 0);
        ch(" ", 0, 0, 7, 1, 0, 0);
        ch(8'h0D, 0, 0, 7, 1, 0, 0);
        ch(8'h0A, 0, 0, 7, 1, 0, 0);
        ch("4", 0, 0, 7, 1, 0, 0);
        ch("5", 0, 0, 7, 1, 0, 0);
        ch(",", 1, 1, 45, 2, 0, 0);
        rst_row();
        ch("9", 0, 0, 0, 0, 0, 0);
        ch("9", 0, 0, 0, 0, 0, 0);
        ch("9", 1, 0, 255, 1, 1, 0);
        ch("0", 0, 0, 255, 1, 1, 0);
        ch("1", 0, 0, 255, 1, 1, 0);
        ch("0", 1, 1, 10, 2, 1, 0);
        rst_row();
        ch("1", 0, 0, 0, 0, 0, 0);
        ch("x", 0, 0, 0, 0, 0, 1);
        ch("2", 0, 0, 0, 0, 0, 1);
        ch(" ", 1, 0, 2, 1, 0, 1);
        rst_row();
        ch("1", 0, 0, 0, 0, 0, 0);
        add(0, 0, 8'h00, 1, 0, 0, 0, 0, 0, 1);
        ch("2", 0, 0, 0, 0, 0, 1);
        ch(" ", 1, 0, 2, 1, 0, 1);
        rst_row();
        ch("4", 0, 0, 0, 0, 0, 0);
        ch("5", 0, 0, 0, 0, 0, 0);
        rst_row();
        ch("6", 0, 0, 0, 0, 0, 0);
        ch(" ", 1, 0, 6, 1, 0, 0);
        add(1, 1, "8", 0, 0, 0, 0, 0, 0, 0);
        ch(" ", 0, 0, 0, 0, 0, 0);
        // Error strobe together with a digit: the digit is discarded.
        ch("3", 0, 0, 0, 0, 0, 0);
        add(0, 1, "4", 1, 0, 0, 0, 0, 0, 1);
        ch(" ", 0, 0, 0, 0, 0, 1);
    endfunction

    logic [7:0] delims [5];
    int         wr_seen;
    bit         ovf_before, fmt_before;

    initial begin
        reset    = 1'b1;
        restart  = 1'b0;
        rx_valid = 1'b0;
        rx_byte  = 8'h00;
        rx_error = 1'b0;
        delims   = '{8'h20, 8'h09, 8'h0D, 8'h0A, 8'h2C};
        m_clear();

        cyc(1, 0, 0, 8'h00, 0);
        chk_model("reset");

        build_table();
        foreach (tbl[i]) begin
            cyc(0, tbl[i].rs, tbl[i].v, tbl[i].b, tbl[i].e);
            chk($sformatf("tbl%0d.wr_en", i), int'(wr_en), int'(tbl[i].wr));
            chk($sformatf("tbl%0d.wr_addr", i), int'(wr_addr), tbl[i].ad);
            chk($sformatf("tbl%0d.wr_data", i), int'(wr_data), tbl[i].da);
            chk($sformatf("tbl%0d.count", i), int'(item_count), tbl[i].cnt);
            chk($sformatf("tbl%0d.done", i), int'(load_done), int'(tbl[i].dn));
            chk($sformatf("tbl%0d.ovf", i), int'(overflow_err), int'(tbl[i].ov));
            chk($sformatf("tbl%0d.fmt", i), int'(format_err), int'(tbl[i].fm));
        end

        // Full load "001".."036", then a 37th number that must be ignored.
        cyc(0, 1, 0, 8'h00, 0);
        for (int n = 1; n <= 36; n++) begin
            cyc(0, 0, 1, 8'h30, 0);
            chk_model("load.d0");
            cyc(0, 0, 1, 8'(8'h30 + n / 10), 0);
            chk_model("load.d1");
            cyc(0, 0, 1, 8'(8'h30 + n % 10), 0);
            chk("load.wr_en", int'(wr_en), 1);
            chk("load.wr_addr", int'(wr_addr), n - 1);
            chk("load.wr_data", int'(wr_data), n);
            chk("load.done", int'(load_done), int'(n == 36));
            cyc(0, 0, 1, 8'h20, 0);
            chk_model("load.sp");
        end
        chk("load.count", int'(item_count), 36);
        ovf_before = overflow_err;
        fmt_before = format_err;
        wr_seen = 0;
        cyc(0, 0, 1, "0", 0); wr_seen += int'(wr_en);
        cyc(0, 0, 1, "3", 0); wr_seen += int'(wr_en);
        cyc(0, 0, 1, "7", 0); wr_seen += int'(wr_en);
        cyc(0, 0, 1, "x", 1); wr_seen += int'(wr_en);
        cyc(0, 0, 0, 8'h00, 1); wr_seen += int'(wr_en);
        chk("done.no_write", wr_seen, 0);
        chk("done.ovf_hold", int'(overflow_err), int'(ovf_before));
        chk("done.fmt_hold", int'(format_err), int'(fmt_before));
        chk("done.still", int'(load_done), 1);
        chk("done.count", int'(item_count), 36);

        // Randomized stream against the model.
        cyc(0, 1, 0, 8'h00, 0);
        for (int k = 0; k < 3000; k++) begin
            int         r;
            bit         v, e, rs, rst;
            logic [7:0] b;
            r   = int'($urandom_range(0, 99));
            v   = 1'b1;
            b   = 8'h00;
            if (r < 55)      b = 8'(8'h30 + $urandom_range(0, 9));
            else if (r < 80) b = delims[$urandom_range(0, 4)];
            else if (r < 88) b = 8'($urandom_range(0, 255));
            else             v = 1'b0;
            e   = ($urandom_range(0, 39) == 0);
            rs  = ($urandom_range(0, 149) == 0);
            rst = ($urandom_range(0, 499) == 0);
            cyc(rst, rs, v, b, e);
            chk_model("rand");
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/dec_stream_loader.md
Name: dec_stream_loader

Overview:
Upstream stage of the matrix-compute top level. Consumes the UART receiver's byte stream (received strobe + rx_byte) and parses ASCII decimal numbers. Each parsed value is written into the downstream operand storage (matrix1, vector and matrix2 arrays) as an indexed write. Replaces the ad-hoc 3-digit accumulation, and adds delimiter handling, overflow and format checking, and an explicit load-complete flag.

Parameters:
VAL_W, 8, width of each stored value
NUM_ITEMS, 36, values per load (16 matrix1 + 4 vector + 16 matrix2)
MAX_DIGITS, 3, digits after which a number auto-commits without a delimiter
ADDR_W, 6, width of wr_addr; must satisfy 2^ADDR_W >= NUM_ITEMS

Ports:
clk  in  1  system clock
reset  in  1  synchronous active-high reset
restart  in  1  single-cycle pulse; clears loader state and flags, same effect as reset
rx_valid  in  1  single-cycle strobe from the UART receiver (received)
rx_byte  in  8  received byte; valid when rx_valid=1
rx_error  in  1  UART framing error strobe (recv_error)
wr_en  out  1  single-cycle write strobe to operand storage
wr_addr  out  ADDR_W  item index 0..NUM_ITEMS-1
wr_data  out  VAL_W  parsed value
item_count  out  ADDR_W  number of items committed so far
load_done  out  1  high once NUM_ITEMS items are committed; sticky
overflow_err  out  1  sticky; a value exceeded 2^VAL_W-1
format_err  out  1  sticky; an illegal character or rx_error was seen

Behaviour:
- Clocking and reset: one clock (clk). Reset is synchronous and active-high. reset or restart zeroes every output, the accumulator, the digit count and the state.
- Character classes:
  - Digit: 0x30-0x39.
  - Delimiter: 0x20, 0x09, 0x0D, 0x0A, 0x2C.
  - Anything else is illegal.
- States:
  - IDLE: no digits pending.
  - ACCUM: at least one digit pending.
  - DONE: load complete.
- IDLE transitions:
  - Digit: acc = d, dcnt = 1, go to ACCUM.
  - Delimiter: ignored, so repeated delimiters and CR/LF pairs never produce empty items.
  - Illegal: set format_err, stay in IDLE.
- ACCUM transitions:
  - Digit: acc = acc*10 + d, dcnt += 1.
  - Delimiter: commit.
  - Illegal byte or rx_error: set format_err, discard the partial number, go to IDLE.
- Auto-commit: when a digit brings dcnt to MAX_DIGITS, commit on that byte. The next byte starts a fresh number.
- Accumulator: internal width VAL_W+4 bits, saturating at its maximum. A leading zero is legal ("045" = 45).
- Commit:
  - wr_en pulses high for exactly one cycle, the cycle after the rx_valid that completed the number (latency 1).
  - wr_addr = item_count before the increment.
  - wr_data = min(acc, 2^VAL_W-1). If clamping occurs, set overflow_err.
  - item_count increments in the same cycle.
  - Return to IDLE.
- Load complete:
  - load_done asserts in the same cycle as the wr_en for item NUM_ITEMS-1, and the FSM enters DONE.
  - In DONE, all rx_valid/rx_error activity is ignored: no writes, no flag changes.
  - Only reset or restart leaves DONE.
- Boundary cases:
  - rx_error while in IDLE: set format_err, nothing else.
  - rx_error and rx_valid in the same cycle: the byte is discarded and handled as illegal.
  - restart and rx_valid in the same cycle: restart wins and the byte is dropped.
  - restart mid-number: the partial number is lost.
  - Back-to-back rx_valid on consecutive cycles must be accepted, giving at most one commit per cycle.
- Between commits, wr_data and wr_addr hold their last values. wr_en=0 outside commit cycles.

Decomposition:
- Shared package holds:
  - ASCII constants: ZERO=0x30, NINE=0x39, SP, TAB, CR, LF, COMMA.
  - Layout constants: MAT1_BASE=0, VEC_BASE=16, MAT2_BASE=20, NUM_ITEMS=36.
  - The state encoding.
- One natural sub-module, ascii_classify: a combinational byte classifier with outputs is_digit, is_delim, is_illegal and digit value. It is reusable by the future command parser.

Test Plan:
1. Bytes '1','2','3' back-to-back with no delimiter -> one wr_en cycle after '3', wr_addr=0, wr_data=123, item_count=1.
2. '7',' ',' ',0x0D,0x0A,'4','5',',' -> exactly two writes: (addr0,7) then (addr1,45); no writes for the extra delimiters.
3. '9','9','9' -> wr_data=255, overflow_err=1; the next item "010" writes 10 and overflow_err stays 1.
4. '1','x','2',' ' -> format_err=1, '1' discarded, single write (addr0,2). Same scenario with rx_error replacing 'x' -> identical result.
5. 36 numbers "001".."036" separated by spaces -> 36 writes, addresses 0..35, data 1..36; load_done rises with the addr35 write. A 37th number produces no wr_en and no flag change.
6. '4','5', restart pulse, '6',' ' -> one write (addr0,6), all flags 0. Also check restart coincident with rx_valid of '8': the byte is dropped.
